// File: rtl/tff_toggle.sv
// Bank of independent toggle flip-flops with a complementary output bus.
// Each bit inverts on a rising clk edge when its t bit is high; rst (active-low) forces RESET_VAL.
module tff_toggle #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] t,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q1
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= RESET_VAL;
        end else begin
            q <= q ^ t;
        end
    end

    // Derived from the register so q1 can never disagree with q, even while in reset.
    assign q1 = ~q;

endmodule

// File: tb/tb_tff_toggle.sv
// Self-checking bench for tff_toggle: a 1-bit and a 4-bit instance, driven by directed and random stimulus.
// Expected state is RESET_VAL plus the parity of the number of enabled edges since the last reset, per bit.
`timescale 1ns/100ps
module tb_tff_toggle;

    localparam logic [3:0] RV2 = 4'b1010;

    logic       clk = 1'b0;
    logic       rst1 = 1'b1;
    logic       rst2 = 1'b1;
    logic [0:0] t1 = 1'b0;
    logic [0:0] q1_out;
    logic [0:0] q1_bar;
    logic [3:0] t2 = 4'b0000;
    logic [3:0] q2_out;
    logic [3:0] q2_bar;

    int checks = 0;
    int errors = 0;
    int cnt1 = 0;
    int cnt2 [4];

    tff_toggle #(.WIDTH(1), .RESET_VAL(1'b0)) dut1 (
        .clk(clk), .rst(rst1), .t(t1), .q(q1_out), .q1(q1_bar)
    );

    tff_toggle #(.WIDTH(4), .RESET_VAL(RV2)) dut2 (
        .clk(clk), .rst(rst2), .t(t2), .q(q2_out), .q1(q2_bar)
    );

    always #2 clk = ~clk;

    // Reference model: the state is the reset value flipped once per enabled edge since reset.
    function automatic logic model1();
        return ((cnt1 % 2) != 0);
    endfunction

    function automatic logic [3:0] model2();
        logic [3:0] r;
        for (int i = 0; i < 4; i++) begin
            r[i] = (((RV2[i] ? 1 : 0) + cnt2[i]) % 2) != 0;
        end
        return r;
    endfunction

    task automatic test_reset();
        rst1 = 1'b0;
        rst2 = 1'b0;
        t1 = 1'b0;
        #1;
        checks++;
        if (q1_out !== 1'b0 || q1_bar !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_initial q=%b q1=%b required q=0 q1=1", q1_out, q1_bar);
        end
        checks++;
        if (q2_out !== RV2 || q2_bar !== ~RV2) begin
            errors++;
            $display("[TB] FAIL reset_initial_wide q=%b q1=%b required q=%b q1=%b", q2_out, q2_bar, RV2, ~RV2);
        end
        @(negedge clk);
        checks++;
        if (q1_out !== 1'b0 || q1_bar !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_after_edge q=%b q1=%b required q=0 q1=1", q1_out, q1_bar);
        end
        #1;
    endtask

    task automatic test_toggle();
        rst1 = 1'b1;
        t1 = 1'b1;
        cnt1 = 0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            cnt1 += int'(t1);
            checks++;
            if (q1_out !== model1() || q1_bar !== ~model1()) begin
                errors++;
                $display("[TB] FAIL toggle_%0d q=%b q1=%b required q=%b q1=%b", k, q1_out, q1_bar, model1(), ~model1());
            end
        end
    endtask

    task automatic test_hold();
        t1 = 1'b0;
        @(negedge clk);
        checks++;
        if (q1_out !== 1'b0 || q1_bar !== 1'b1) begin
            errors++;
            $display("[TB] FAIL hold q=%b q1=%b required q=0 q1=1", q1_out, q1_bar);
        end
        // A pulse on t that is gone before the rising edge must not toggle.
        #0.5 t1 = 1'b1;
        #0.5 t1 = 1'b0;
        @(negedge clk);
        checks++;
        if (q1_out !== 1'b0 || q1_bar !== 1'b1) begin
            errors++;
            $display("[TB] FAIL hold_glitch q=%b q1=%b required q=0 q1=1", q1_out, q1_bar);
        end
    endtask

    task automatic test_pulse();
        logic [0:0] pattern [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        for (int k = 0; k < 4; k++) begin
            t1 = pattern[k];
            @(negedge clk);
            cnt1 += int'(t1);
            checks++;
            if (q1_out !== model1() || q1_bar !== ~q1_out) begin
                errors++;
                $display("[TB] FAIL pulse_%0d q=%b q1=%b required q=%b q1=%b", k, q1_out, q1_bar, model1(), ~model1());
            end
        end
        t1 = 1'b0;
    endtask

    task automatic test_async_reset();
        checks++;
        if (q1_out !== 1'b1) begin
            errors++;
            $display("[TB] FAIL async_precondition q=%b required q=1", q1_out);
        end
        rst1 = 1'b0;
        #1;
        checks++;
        if (q1_out !== 1'b0 || q1_bar !== 1'b1) begin
            errors++;
            $display("[TB] FAIL async_immediate q=%b q1=%b required q=0 q1=1", q1_out, q1_bar);
        end
        t1 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (q1_out !== 1'b0 || q1_bar !== 1'b1) begin
                errors++;
                $display("[TB] FAIL async_held_%0d q=%b q1=%b required q=0 q1=1", k, q1_out, q1_bar);
            end
        end
        t1 = 1'b0;
        rst1 = 1'b1;
        cnt1 = 0;
    endtask

    task automatic test_wide();
        checks++;
        if (q2_out !== 4'b1010 || q2_bar !== 4'b0101) begin
            errors++;
            $display("[TB] FAIL wide_reset q=%b q1=%b required q=1010 q1=0101", q2_out, q2_bar);
        end
        rst2 = 1'b1;
        t2 = 4'b0110;
        @(negedge clk);
        checks++;
        if (q2_out !== 4'b1100 || q2_bar !== 4'b0011) begin
            errors++;
            $display("[TB] FAIL wide_toggle q=%b q1=%b required q=1100 q1=0011", q2_out, q2_bar);
        end
        for (int i = 0; i < 4; i++) cnt2[i] = t2[i] ? 1 : 0;
        t2 = 4'b0000;
    endtask

    task automatic test_random();
        logic [3:0] exp2;
        for (int k = 0; k < 300; k++) begin
            t1 = 1'($urandom);
            t2 = 4'($urandom);
            @(negedge clk);
            cnt1 += int'(t1);
            for (int i = 0; i < 4; i++) cnt2[i] += t2[i] ? 1 : 0;
            exp2 = model2();
            checks++;
            if (q1_out !== model1() || q1_bar !== ~model1()) begin
                errors++;
                $display("[TB] FAIL random1_%0d q=%b q1=%b required q=%b q1=%b", k, q1_out, q1_bar, model1(), ~model1());
            end
            checks++;
            if (q2_out !== exp2 || q2_bar !== ~exp2) begin
                errors++;
                $display("[TB] FAIL random4_%0d q=%b q1=%b required q=%b q1=%b", k, q2_out, q2_bar, exp2, ~exp2);
            end
            if ($urandom_range(0, 19) == 0) begin
                rst1 = 1'b0;
                rst2 = 1'b0;
                #0.5;
                checks++;
                if (q1_out !== 1'b0 || q2_out !== RV2 || q2_bar !== ~RV2) begin
                    errors++;
                    $display("[TB] FAIL random_reset_%0d q=%b q4=%b q4_1=%b required q=0 q4=%b q4_1=%b", k, q1_out, q2_out, q2_bar, RV2, ~RV2);
                end
                #0.5;
                rst1 = 1'b1;
                rst2 = 1'b1;
                cnt1 = 0;
                for (int i = 0; i < 4; i++) cnt2[i] = 0;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) cnt2[i] = 0;
        test_reset();
        test_toggle();
        test_hold();
        test_pulse();
        test_async_reset();
        test_wide();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
